// File: rtl/vend_txn_ctrl.sv
// vend_txn_ctrl: transaction sequencer for the vending datapath.
// Adds up coin strobes into a credit register. Once credit reaches PRICE it
// requests one item from the dispenser, then pays out any change. On cancel
// or idle timeout it refunds the whole credit instead. Change and refunds
// are paid as single-unit pulses.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   coin       coin strobe: 01=1 unit, 10=2 units, 11=3 units
//   cancel     customer cancel pulse
//   disp_ack   dispenser done; only looked at while disp_req=1
//   coin_en    acceptor enable; coins are ignored while low
//   disp_req   dispense request, held high until disp_ack
//   chg_pulse  one high cycle per unit returned
//   credit     current credit in units
//   busy       high in every state except IDLE
module vend_txn_ctrl #(
  parameter int unsigned PRICE   = 4,
  parameter int unsigned CW      = 4,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    coin,
  input  logic          cancel,
  input  logic          disp_ack,
  output logic          coin_en,
  output logic          disp_req,
  output logic          chg_pulse,
  output logic [CW-1:0] credit,
  output logic          busy
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    COLLECT  = 5'b00010,
    DISPENSE = 5'b00100,
    CHANGE   = 5'b01000,
    REFUND   = 5'b10000
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            coin_en_q, coin_en_d;
  logic            disp_req_q, disp_req_d;
  logic            chg_q, chg_d;
  logic            busy_q, busy_d;

  logic            coin_ok;
  logic [CW-1:0]   credit_sum;
  logic [CW-1:0]   credit_left;

  // Coins count only while the acceptor is enabled; the sum cannot overflow
  // because credit stays below PRICE until a coin is added.
  assign coin_ok     = coin_en_q && (coin != 2'b00);
  assign credit_sum  = credit_q + CW'(coin);
  assign credit_left = credit_q - CW'(PRICE);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      timer_q    <= '0;
      coin_en_q  <= 1'b0;
      disp_req_q <= 1'b0;
      chg_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      timer_q    <= timer_d;
      coin_en_q  <= coin_en_d;
      disp_req_q <= disp_req_d;
      chg_q      <= chg_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    timer_d    = '0;
    disp_req_d = 1'b0;
    chg_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (coin_ok) begin
          credit_d = credit_sum;
          if (credit_sum >= CW'(PRICE)) begin
            state_d    = DISPENSE;
            disp_req_d = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end
      end

      COLLECT: begin
        if (coin_ok) begin
          credit_d = credit_sum;
        end
        // Cancel wins over reaching the price; a same-cycle coin is refunded too.
        if (cancel) begin
          state_d = REFUND;
          chg_d   = 1'b1;
        end else if (coin_ok) begin
          if (credit_sum >= CW'(PRICE)) begin
            state_d    = DISPENSE;
            disp_req_d = 1'b1;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = REFUND;
          chg_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      DISPENSE: begin
        disp_req_d = 1'b1;
        if (disp_ack && disp_req_q) begin
          disp_req_d = 1'b0;
          credit_d   = credit_left;
          if (credit_left != '0) begin
            state_d = CHANGE;
            chg_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      // Pulse high one cycle, low one cycle per unit; leave after the last low.
      CHANGE, REFUND: begin
        if (chg_q) begin
          credit_d = credit_q - CW'(1);
        end else if (credit_q == '0) begin
          state_d = IDLE;
        end else begin
          chg_d = 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase

    coin_en_d = (state_d == IDLE) || (state_d == COLLECT);
    busy_d    = (state_d != IDLE);
  end

  assign coin_en   = coin_en_q;
  assign disp_req  = disp_req_q;
  assign chg_pulse = chg_q;
  assign credit    = credit_q;
  assign busy      = busy_q;

endmodule
